// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with a per-register pending-write scoreboard.
// x0 is hardwired to zero. A same-cycle write can optionally be forwarded to the read ports.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NRD*$clog2(NREG)-1:0] rs_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rs_busy,
    input  logic                  we,
    input  logic [$clog2(NREG)-1:0] wa,
    input  logic [XLEN-1:0]       wd,
    input  logic                  iss_valid,
    input  logic [$clog2(NREG)-1:0] iss_rd,
    output logic                  busy_any
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs_r [NREG];
    logic [NREG-1:0] pend_r;
    logic [NREG-1:0] pend_next_s;
    logic            wr_en_s;
    logic            iss_en_s;

    assign wr_en_s  = we && (wa != {AW{1'b0}});
    assign iss_en_s = iss_valid && (iss_rd != {AW{1'b0}});

    // Scoreboard next state: the retiring write clears first, so a younger issue to the same register wins
    always_comb begin
        pend_next_s = pend_r;
        if (wr_en_s) begin
            pend_next_s[wa] = 1'b0;
        end else begin
            pend_next_s = pend_next_s;
        end
        if (iss_en_s) begin
            pend_next_s[iss_rd] = 1'b1;
        end else begin
            pend_next_s = pend_next_s;
        end
    end

    // Storage and pending bits; reset overrides any write or issue in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
            pend_r <= {NREG{1'b0}};
        end else begin
            if (wr_en_s) begin
                regs_r[wa] <= wd;
            end
            pend_r <= pend_next_s;
        end
    end

    // Aggregate busy flag, forced quiet while reset is asserted
    always_comb begin
        if (!reset_n) begin
            busy_any = 1'b0;
        end else begin
            busy_any = |pend_r;
        end
    end

    genvar p;
    generate
        for (p = 0; p < NRD; p++) begin : g_rd
            logic [AW-1:0] addr_s;
            logic          fwd_s;

            assign addr_s = rs_addr[p*AW +: AW];
            assign fwd_s  = (BYPASS != 0) && we && (wa == addr_s);

            // Read port: zero register, then forwarded write data, then storage
            always_comb begin
                if (!reset_n) begin
                    rd_data[p*XLEN +: XLEN] = {XLEN{1'b0}};
                    rs_busy[p]              = 1'b0;
                end else if (addr_s == {AW{1'b0}}) begin
                    rd_data[p*XLEN +: XLEN] = {XLEN{1'b0}};
                    rs_busy[p]              = 1'b0;
                end else if (fwd_s) begin
                    rd_data[p*XLEN +: XLEN] = wd;
                    rs_busy[p]              = 1'b0;
                end else begin
                    rd_data[p*XLEN +: XLEN] = regs_r[addr_s];
                    rs_busy[p]              = pend_r[addr_s];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed checks on 32x32 instances with and without bypass,
// then random traffic on a 16x64, 4-port instance against an array-based reference model.
module tb_regfile_mp;

    logic clk_s = 1'b0;
    logic reset_n_s;
    int   total_cnt = 0;
    int   bad_cnt   = 0;

    always #5 clk_s = ~clk_s;

    // Instances A (bypass) and B (no bypass) share inputs: 32 regs, 2 ports, 32 bits
    logic [9:0]  ab_rs_addr_s;
    logic        ab_we_s;
    logic [4:0]  ab_wa_s;
    logic [31:0] ab_wd_s;
    logic        ab_iss_valid_s;
    logic [4:0]  ab_iss_rd_s;
    logic [63:0] a_rd_data_s, b_rd_data_s;
    logic [1:0]  a_rs_busy_s, b_rs_busy_s;
    logic        a_busy_any_s, b_busy_any_s;

    // Instance C: 16 regs, 4 ports, 64 bits
    logic [15:0]  c_rs_addr_s;
    logic         c_we_s;
    logic [3:0]   c_wa_s;
    logic [63:0]  c_wd_s;
    logic         c_iss_valid_s;
    logic [3:0]   c_iss_rd_s;
    logic [255:0] c_rd_data_s;
    logic [3:0]   c_rs_busy_s;
    logic         c_busy_any_s;

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) u_a (
        .clk(clk_s), .reset_n(reset_n_s), .rs_addr(ab_rs_addr_s), .rd_data(a_rd_data_s),
        .rs_busy(a_rs_busy_s), .we(ab_we_s), .wa(ab_wa_s), .wd(ab_wd_s),
        .iss_valid(ab_iss_valid_s), .iss_rd(ab_iss_rd_s), .busy_any(a_busy_any_s));

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0)) u_b (
        .clk(clk_s), .reset_n(reset_n_s), .rs_addr(ab_rs_addr_s), .rd_data(b_rd_data_s),
        .rs_busy(b_rs_busy_s), .we(ab_we_s), .wa(ab_wa_s), .wd(ab_wd_s),
        .iss_valid(ab_iss_valid_s), .iss_rd(ab_iss_rd_s), .busy_any(b_busy_any_s));

    regfile_mp #(.XLEN(64), .NREG(16), .NRD(4), .BYPASS(1)) u_c (
        .clk(clk_s), .reset_n(reset_n_s), .rs_addr(c_rs_addr_s), .rd_data(c_rd_data_s),
        .rs_busy(c_rs_busy_s), .we(c_we_s), .wa(c_wa_s), .wd(c_wd_s),
        .iss_valid(c_iss_valid_s), .iss_rd(c_iss_rd_s), .busy_any(c_busy_any_s));

    // Reference state for instance C
    logic [63:0] m_reg [16];
    bit          m_pend [16];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_s);
        #1;
    endtask

    task automatic drive_ab(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic iss, input logic [4:0] rd,
                            input logic [4:0] addr0, input logic [4:0] addr1);
        ab_we_s        = we;
        ab_wa_s        = wa;
        ab_wd_s        = wd;
        ab_iss_valid_s = iss;
        ab_iss_rd_s    = rd;
        ab_rs_addr_s   = {addr1, addr0};
        #2;
    endtask

    initial begin
        logic [3:0]  a;
        logic [63:0] exp_d;
        bit          exp_b;
        bit          any_p;

        c_we_s = 1'b0; c_wa_s = 4'd0; c_wd_s = 64'd0; c_iss_valid_s = 1'b0;
        c_iss_rd_s = 4'd0; c_rs_addr_s = 16'd0;

        // Reset held two cycles while a write to x5 is attempted
        reset_n_s = 1'b0;
        drive_ab(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd5);
        check_val("rst_during_rd", {32'd0, a_rd_data_s[31:0]}, 64'd0);
        step();
        step();
        check_val("rst_during_busy", {62'd0, a_rs_busy_s}, 64'd0);
        reset_n_s = 1'b1;
        drive_ab(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
        check_val("rst_x5", {32'd0, a_rd_data_s[31:0]}, 64'd0);
        check_val("rst_busy_any", {63'd0, a_busy_any_s}, 64'd0);
        check_val("rst_c_busy_any", {63'd0, c_busy_any_s}, 64'd0);

        // Write x7, read on both ports next cycle
        drive_ab(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        drive_ab(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);
        check_val("x7_p0", {32'd0, a_rd_data_s[31:0]}, 64'h1234_5678);
        check_val("x7_p1", {32'd0, a_rd_data_s[63:32]}, 64'h1234_5678);
        check_val("x7_b_p1", {32'd0, b_rd_data_s[63:32]}, 64'h1234_5678);

        // x0 write is discarded
        drive_ab(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 5'd0);
        check_val("x0_same", {32'd0, a_rd_data_s[31:0]}, 64'd0);
        step();
        drive_ab(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        check_val("x0_p0", {32'd0, a_rd_data_s[31:0]}, 64'd0);
        check_val("x0_p1", {32'd0, a_rd_data_s[63:32]}, 64'd0);

        // Bypass vs. no bypass
        drive_ab(1'b1, 5'd3, 32'h1111_1111, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        drive_ab(1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, 5'd0, 5'd0, 5'd3);
        check_val("byp_a_p1", {32'd0, a_rd_data_s[63:32]}, 64'hA5A5_A5A5);
        check_val("nobyp_b_p1", {32'd0, b_rd_data_s[63:32]}, 64'h1111_1111);
        step();
        drive_ab(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd3);
        check_val("nobyp_b_next", {32'd0, b_rd_data_s[63:32]}, 64'hA5A5_A5A5);

        // Scoreboard: issue x9, then retire it
        drive_ab(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        check_val("iss_same_busy", {62'd0, a_rs_busy_s}, 64'd0);
        check_val("iss_same_any", {63'd0, a_busy_any_s}, 64'd0);
        step();
        drive_ab(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        check_val("x9_busy", {62'd0, a_rs_busy_s}, 64'd1);
        check_val("x9_any", {63'd0, a_busy_any_s}, 64'd1);
        drive_ab(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 5'd9, 5'd0);
        check_val("x9_wr_busy_a", {62'd0, a_rs_busy_s}, 64'd0);
        check_val("x9_wr_data_a", {32'd0, a_rd_data_s[31:0]}, 64'h99);
        check_val("x9_wr_busy_b", {62'd0, b_rs_busy_s}, 64'd1);
        check_val("x9_wr_data_b", {32'd0, b_rd_data_s[31:0]}, 64'd0);
        step();
        drive_ab(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        check_val("x9_clr_busy_b", {62'd0, b_rs_busy_s}, 64'd0);
        check_val("x9_clr_any", {63'd0, a_busy_any_s}, 64'd0);
        check_val("x9_data_b", {32'd0, b_rd_data_s[31:0]}, 64'h99);

        // Same-edge set and clear on x4: set wins
        drive_ab(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd0, 5'd0);
        step();
        drive_ab(1'b1, 5'd4, 32'h0000_0044, 1'b1, 5'd4, 5'd0, 5'd0);
        step();
        drive_ab(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd0);
        check_val("x4_setwins", {62'd0, a_rs_busy_s}, 64'd1);
        check_val("x4_data", {32'd0, a_rd_data_s[31:0]}, 64'h44);
        drive_ab(1'b1, 5'd4, 32'h0000_0045, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        drive_ab(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        step();
        drive_ab(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        check_val("x0_iss_any", {63'd0, a_busy_any_s}, 64'd0);

        // Reset mid-operation drops pending state and data
        drive_ab(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd10, 5'd7);
        step();
        drive_ab(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd10, 5'd7);
        check_val("x10_any", {63'd0, a_busy_any_s}, 64'd1);
        reset_n_s = 1'b0;
        step();
        reset_n_s = 1'b1;
        #2;
        check_val("midrst_any", {63'd0, a_busy_any_s}, 64'd0);
        check_val("midrst_busy", {62'd0, a_rs_busy_s}, 64'd0);
        check_val("midrst_x7", {32'd0, a_rd_data_s[63:32]}, 64'd0);

        // Random traffic on instance C against the reference model
        for (int i = 0; i < 16; i++) begin
            m_reg[i]  = 64'd0;
            m_pend[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            c_we_s        = ($urandom_range(0, 2) != 0);
            c_wa_s        = 4'($urandom_range(0, 15));
            c_wd_s        = {$urandom, $urandom};
            c_iss_valid_s = ($urandom_range(0, 2) == 0);
            c_iss_rd_s    = ($urandom_range(0, 3) == 0) ? c_wa_s : 4'($urandom_range(0, 15));
            for (int p = 0; p < 4; p++) begin
                c_rs_addr_s[p*4 +: 4] = ($urandom_range(0, 3) == 0) ? c_wa_s : 4'($urandom_range(0, 15));
            end
            #2;
            any_p = 1'b0;
            for (int r = 0; r < 16; r++) begin
                any_p = any_p | m_pend[r];
            end
            for (int p = 0; p < 4; p++) begin
                a = c_rs_addr_s[p*4 +: 4];
                if (a == 4'd0) begin
                    exp_d = 64'd0;
                    exp_b = 1'b0;
                end else if (c_we_s && c_wa_s == a) begin
                    exp_d = c_wd_s;
                    exp_b = 1'b0;
                end else begin
                    exp_d = m_reg[a];
                    exp_b = m_pend[a];
                end
                check_val($sformatf("rnd%0d_p%0d_data", cyc, p), c_rd_data_s[p*64 +: 64], exp_d);
                check_val($sformatf("rnd%0d_p%0d_busy", cyc, p), {63'd0, c_rs_busy_s[p]}, {63'd0, exp_b});
            end
            check_val($sformatf("rnd%0d_any", cyc), {63'd0, c_busy_any_s}, {63'd0, any_p});
            if (c_we_s && c_wa_s != 4'd0) begin
                m_reg[c_wa_s]  = c_wd_s;
                m_pend[c_wa_s] = 1'b0;
            end
            if (c_iss_valid_s && c_iss_rd_s != 4'd0) begin
                m_pend[c_iss_rd_s] = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
